bundle_unpack_rx: RTL and testbench
===================================

# bundle_unpack_rx

Receive side of the packed-bundle link: reassembles the 63-bit flattened bundle word from narrow beats and splits it back into named fields. It is the inverse of the bundle packer, which concatenates a 6-slot aggregate into one UInt. It sits at the sink end of a serial link, between a beat-wide valid/ready stream and the consumer of the reconstructed bundle. It buffers one complete word, so assembly of the next word overlaps with drain of the current one.

## Interface
- BEAT_W, 16, beat width in bits; legal range 1..63.
- BEATS, ceil(63/BEAT_W) (derived, not overridable), beats per word.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  BEAT_W  beat payload; beat k carries word bits [k*BEAT_W +: BEAT_W], LSB beat first.
- in_last  in  1  sender marks final beat of a word.
- out_valid  out  1  unpacked word held.
- out_ready  in  1  consumer accepts word.
- out_a  out  10  word[62:53].
- out_bar_c_1  out  1  word[52].
- out_bar_d_1  out  20  word[51:32].
- out_bar_c_0  out  1  word[31].
- out_bar_d_0  out  20  word[30:11].
- out_b  out  11  word[10:0].
- out_err  out  1  framing error for the held word; qualified by out_valid.

## Operation
- Datapath: assembly register asm[63:0], beat counter cnt (0..BEATS-1), output register holding the 63-bit word and the error bit.
- Accepted beat at cnt=k writes in_data into asm[k*BEAT_W +: BEAT_W]. Bits at index ≥63 of the final beat are discarded.
- A word completes on the accepted beat where cnt==BEATS-1 or in_last==1, whichever comes first.
- On completion: word ← asm merged with the current beat. Bits above the last written beat are forced to 0. out_err ← (in_last != (cnt==BEATS-1)). out_valid ← 1. cnt ← 0. asm ← 0.
- Early in_last (cnt<BEATS-1): short word, zero-filled, out_err=1.
- Missing in_last on beat BEATS-1: word completes anyway with out_err=1. The next beat starts a new word.
- Field outputs are direct slices of the output register; no combinational path from in_data to outputs.
- in_ready = !(completing_beat_pending && out_valid && !out_ready). Here completing_beat_pending is (cnt==BEATS-1 || in_last). Non-final beats are never stalled.
- out_valid clears on out_valid && out_ready unless a completion loads a new word in the same cycle; in that case out_valid stays 1 with the new contents.

## Timing
- Reset (async assert, sync release) gives: out_valid=0, out_err=0, all field outputs 0, cnt=0, asm=0.
- in_ready is 1 out of reset.
- Latency: out_valid rises the cycle after the completing beat is accepted.
- Throughput: one beat per cycle sustained when out_ready is held high. A word every BEATS cycles with no bubbles.
- Simultaneous drain and completion: both take effect in the same edge, so back-to-back words are not lost.
- in_ready may depend combinationally on out_ready and in_last. out_valid and all fields are registered.
- Reset mid-word discards the partial word. The first post-reset beat is beat 0.
- Held word and out_err stay stable while out_valid && !out_ready.

## Test plan
- BEAT_W=16, beats 0x05A5, 0x8000, 0x0000, 0x7FE0 with last on beat 3 → out_b=0x5A5, out_bar_c_0=1, out_a=0x3FF, other fields 0, out_err=0, out_valid one cycle after beat 3.
- Back-to-back words with out_ready=1 and in_valid continuous → in_ready stays 1 and 8 beats yield 2 words on consecutive completions. No stall, no drop.
- out_ready=0 while word 1 is held; word 2 beats 0..2 are accepted and beat 3 stalls with in_ready=0. Raise out_ready → word 1 drains, word 2 loads in the same edge, out_valid stays 1.
- in_last on beat 1 with data 0xFFFF, 0xFFFF → out_b=0x7FF, out_bar_d_0=0xFFFFF, out_bar_c_0=1, upper fields 0, out_err=1. Next beat is treated as beat 0.
- No in_last on beat 3 → word completes with out_err=1. Following well-formed word → out_err=0.
- reset_n pulsed low after 2 beats → all outputs 0 immediately. Fresh 4-beat word after release decodes correctly.
- BEAT_W=7 (BEATS=9): word 63'h7FFF_FFFF_FFFF_FFFF as nine 0x7F beats → every field all-ones, out_err=0.

Source files
------------

// File: rtl/bundle_unpack_rx.sv
// Reassembles a 63-bit bundle word from narrow beats and exposes its fields.
// One held word plus one in assembly; framing errors flagged per word.
module bundle_unpack_rx #(
    parameter int BEAT_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9:0]        out_a,
    output logic              out_bar_c_1,
    output logic [19:0]       out_bar_d_1,
    output logic              out_bar_c_0,
    output logic [19:0]       out_bar_d_0,
    output logic [10:0]       out_b,
    output logic              out_err
);

    localparam int BEATS = (63 + BEAT_W - 1) / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ASM_W = BEATS * BEAT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ASM_W-1:0] asm_q, asm_d;
    logic [ASM_W-1:0] merged;
    logic [62:0]      word_q, word_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic             final_beat;
    logic             ends_word;
    logic             fire;
    logic             complete;

    always_comb begin
        final_beat = (cnt_q == LAST_CNT);
        ends_word  = final_beat || in_last;
        // Only a word-ending beat needs the output slot to be free.
        in_ready   = !(ends_word && valid_q && !out_ready);
        fire       = in_valid && in_ready;
        complete   = fire && ends_word;
        merged     = asm_q | (ASM_W'(in_data) << (int'(cnt_q) * BEAT_W));

        cnt_d   = cnt_q;
        asm_d   = asm_q;
        word_d  = word_q;
        err_d   = err_q;
        valid_d = valid_q;

        if (fire) begin
            if (ends_word) begin
                cnt_d  = '0;
                asm_d  = '0;
                word_d = merged[62:0];
                err_d  = (in_last != final_beat);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                asm_d = merged;
            end
        end

        if (complete) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            word_q  <= word_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_err     = err_q;
    assign out_a       = word_q[62:53];
    assign out_bar_c_1 = word_q[52];
    assign out_bar_d_1 = word_q[51:32];
    assign out_bar_c_0 = word_q[31];
    assign out_bar_d_0 = word_q[30:11];
    assign out_b       = word_q[10:0];

endmodule

// File: tb/tb_bundle_unpack_rx.sv
// Directed bench for bundle_unpack_rx at BEAT_W=16 and BEAT_W=7.
// Each scenario task checks its own hand-computed results.
module tb_bundle_unpack_rx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [9:0]  out_a;
    logic        out_bar_c_1;
    logic [19:0] out_bar_d_1;
    logic        out_bar_c_0;
    logic [19:0] out_bar_d_0;
    logic [10:0] out_b;
    logic        out_err;

    logic        v_in_valid = 1'b0;
    logic        v_in_ready;
    logic [6:0]  v_in_data = '0;
    logic        v_in_last = 1'b0;
    logic        v_out_valid;
    logic        v_out_ready = 1'b1;
    logic [9:0]  v_out_a;
    logic        v_out_bar_c_1;
    logic [19:0] v_out_bar_d_1;
    logic        v_out_bar_c_0;
    logic [19:0] v_out_bar_d_0;
    logic [10:0] v_out_b;
    logic        v_out_err;

    int checks = 0;
    int passed = 0;

    wire [62:0] f = {out_a, out_bar_c_1, out_bar_d_1,
                     out_bar_c_0, out_bar_d_0, out_b};
    wire [62:0] vf = {v_out_a, v_out_bar_c_1, v_out_bar_d_1,
                      v_out_bar_c_0, v_out_bar_d_0, v_out_b};

    always #5 clock = ~clock;

    bundle_unpack_rx #(.BEAT_W(16)) u16 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_bar_c_1(out_bar_c_1),
        .out_bar_d_1(out_bar_d_1), .out_bar_c_0(out_bar_c_0),
        .out_bar_d_0(out_bar_d_0), .out_b(out_b),
        .out_err(out_err)
    );

    bundle_unpack_rx #(.BEAT_W(7)) u7 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(v_in_valid), .in_ready(v_in_ready),
        .in_data(v_in_data), .in_last(v_in_last),
        .out_valid(v_out_valid), .out_ready(v_out_ready),
        .out_a(v_out_a), .out_bar_c_1(v_out_bar_c_1),
        .out_bar_d_1(v_out_bar_d_1), .out_bar_c_0(v_out_bar_c_0),
        .out_bar_d_0(v_out_bar_d_0), .out_b(v_out_b),
        .out_err(v_out_err)
    );

    // Presents one beat for one edge; reports whether it was accepted.
    task automatic drive(input logic [15:0] d, input logic l,
                         output logic acc);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        acc = in_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || f !== 63'd0)
            $display("FAIL reset_state: valid=%b err=%b word=%h want 0/0/0",
                     out_valid, out_err, f);
        else passed++;
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || v_in_ready !== 1'b1 || v_out_valid !== 1'b0)
            $display("FAIL reset_ready: in_ready=%b v_in_ready=%b v_valid=%b",
                     in_ready, v_in_ready, v_out_valid);
        else passed++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        logic acc;
        logic all_acc;
        all_acc = 1'b1;
        out_ready = 1'b1;
        drive(16'h05A5, 1'b0, acc); all_acc &= acc;
        drive(16'h8000, 1'b0, acc); all_acc &= acc;
        drive(16'h0000, 1'b0, acc); all_acc &= acc;
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL basic_early_valid: got %b want 0", out_valid);
        else passed++;
        drive(16'h7FE0, 1'b1, acc); all_acc &= acc;
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || !all_acc)
            $display("FAIL basic_valid: valid=%b err=%b acc=%b want 1/0/1",
                     out_valid, out_err, all_acc);
        else passed++;
        checks++;
        if (f !== 63'h7FE0_0000_8000_05A5)
            $display("FAIL basic_word: got %h want %h",
                     f, 63'h7FE0_0000_8000_05A5);
        else passed++;
        checks++;
        if (out_b !== 11'h5A5 || out_bar_c_0 !== 1'b1 || out_a !== 10'h3FF)
            $display("FAIL basic_fields: b=%h c0=%b a=%h want 5a5/1/3ff",
                     out_b, out_bar_c_0, out_a);
        else passed++;
        @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL basic_drain: valid=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic all_acc;
        logic [15:0] beats [8];
        beats = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                  16'h000A, 16'h0000, 16'h0000, 16'h0020};
        all_acc = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(beats[i], (i % 4) == 3, acc);
            all_acc &= acc;
            if (i == 3) begin
                checks++;
                if (out_valid !== 1'b1 || f !== 63'h0004_0003_0002_0001)
                    $display("FAIL b2b_word0: valid=%b word=%h want 1/%h",
                             out_valid, f, 63'h0004_0003_0002_0001);
                else passed++;
            end
        end
        idle();
        checks++;
        if (out_valid !== 1'b1 || f !== 63'h0020_0000_0000_000A
            || out_a !== 10'h001)
            $display("FAIL b2b_word1: valid=%b word=%h want 1/%h",
                     out_valid, f, 63'h0020_0000_0000_000A);
        else passed++;
        checks++;
        if (all_acc !== 1'b1)
            $display("FAIL b2b_no_stall: in_ready dropped, got %b want 1",
                     all_acc);
        else passed++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_stall();
        logic acc;
        logic all_acc;
        out_ready = 1'b0;
        drive(16'h0111, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        drive(16'h0000, 1'b1, acc);
        all_acc = 1'b1;
        drive(16'h0222, 1'b0, acc); all_acc &= acc;
        drive(16'h0000, 1'b0, acc); all_acc &= acc;
        drive(16'h0000, 1'b0, acc); all_acc &= acc;
        checks++;
        if (all_acc !== 1'b1 || out_valid !== 1'b1 || f !== 63'h111)
            $display("FAIL stall_hold: acc=%b valid=%b word=%h want 1/1/111",
                     all_acc, out_valid, f);
        else passed++;
        in_valid = 1'b1;
        in_data  = 16'h0000;
        in_last  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0)
            $display("FAIL stall_ready: in_ready=%b want 0", in_ready);
        else passed++;
        @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b1 || f !== 63'h111)
            $display("FAIL stall_stable: valid=%b word=%h want 1/111",
                     out_valid, f);
        else passed++;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1)
            $display("FAIL stall_release: in_ready=%b want 1", in_ready);
        else passed++;
        @(posedge clock);
        #1;
        idle();
        checks++;
        if (out_valid !== 1'b1 || f !== 63'h222 || out_err !== 1'b0)
            $display("FAIL stall_swap: valid=%b word=%h err=%b want 1/222/0",
                     out_valid, f, out_err);
        else passed++;
        @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL stall_drain: valid=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_short_word();
        logic acc;
        out_ready = 1'b1;
        drive(16'hFFFF, 1'b0, acc);
        drive(16'hFFFF, 1'b1, acc);
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1
            || f !== 63'h0000_0000_FFFF_FFFF)
            $display("FAIL short_word: valid=%b err=%b word=%h want 1/1/%h",
                     out_valid, out_err, f, 63'h0000_0000_FFFF_FFFF);
        else passed++;
        checks++;
        if (out_b !== 11'h7FF || out_bar_d_0 !== 20'hFFFFF
            || out_bar_c_0 !== 1'b1 || out_bar_d_1 !== 20'h0)
            $display("FAIL short_fields: b=%h d0=%h c0=%b d1=%h",
                     out_b, out_bar_d_0, out_bar_c_0, out_bar_d_1);
        else passed++;
        drive(16'h0003, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        drive(16'h0000, 1'b1, acc);
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || f !== 63'h3)
            $display("FAIL short_next: valid=%b err=%b word=%h want 1/0/3",
                     out_valid, out_err, f);
        else passed++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_missing_last();
        logic acc;
        out_ready = 1'b1;
        drive(16'h0001, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || f !== 63'h1)
            $display("FAIL missing_last: valid=%b err=%b word=%h want 1/1/1",
                     out_valid, out_err, f);
        else passed++;
        drive(16'h0005, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        drive(16'h0000, 1'b1, acc);
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || f !== 63'h5)
            $display("FAIL missing_next: valid=%b err=%b word=%h want 1/0/5",
                     out_valid, out_err, f);
        else passed++;
    endtask

    task automatic test_mid_reset();
        logic acc;
        out_ready = 1'b0;
        drive(16'hFFFF, 1'b0, acc);
        drive(16'hFFFF, 1'b0, acc);
        idle();
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || f !== 63'd0)
            $display("FAIL mid_reset: valid=%b err=%b word=%h want 0/0/0",
                     out_valid, out_err, f);
        else passed++;
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        drive(16'h0777, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        drive(16'h0000, 1'b0, acc);
        drive(16'h4000, 1'b1, acc);
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b0
            || f !== 63'h4000_0000_0000_0777)
            $display("FAIL post_reset: valid=%b err=%b word=%h want 1/0/%h",
                     out_valid, out_err, f, 63'h4000_0000_0000_0777);
        else passed++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_beat_w7();
        logic all_acc;
        all_acc = 1'b1;
        for (int i = 0; i < 9; i++) begin
            v_in_valid = 1'b1;
            v_in_data  = 7'h7F;
            v_in_last  = (i == 8);
            #1;
            all_acc &= v_in_ready;
            @(posedge clock);
            #1;
            if (i == 7) begin
                checks++;
                if (v_out_valid !== 1'b0)
                    $display("FAIL w7_early: valid=%b want 0", v_out_valid);
                else passed++;
            end
        end
        v_in_valid = 1'b0;
        v_in_last  = 1'b0;
        checks++;
        if (v_out_valid !== 1'b1 || v_out_err !== 1'b0 || !all_acc)
            $display("FAIL w7_valid: valid=%b err=%b acc=%b want 1/0/1",
                     v_out_valid, v_out_err, all_acc);
        else passed++;
        checks++;
        if (vf !== 63'h7FFF_FFFF_FFFF_FFFF)
            $display("FAIL w7_word: got %h want %h",
                     vf, 63'h7FFF_FFFF_FFFF_FFFF);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_short_word();
        test_missing_last();
        test_mid_reset();
        test_beat_w7();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past 100000 time units");
        $fatal(1);
    end

endmodule
